// File: rtl/fixedpoint_pkg.sv
// Q16.16 fixed-point types and constants shared by the arithmetic units.
// The divider's state enum lives here too.
package fixedpoint;

   localparam int WIDTH     = 32;
   localparam int FRAC      = 16;
   localparam int DIV_STEPS = WIDTH + FRAC;

   typedef logic signed [WIDTH-1:0] number;

   localparam logic [WIDTH-1:0] MAX_POS = 32'h7FFF_FFFF;
   localparam logic [WIDTH-1:0] MIN_NEG = 32'h8000_0000;

   typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

   // The most negative value maps to 0x80000000, which is still correct as an unsigned magnitude.
   function automatic logic [WIDTH-1:0] abs_u(input number x);
      logic [WIDTH-1:0] u;
      u = x;
      return x[WIDTH-1] ? (~u + WIDTH'(1)) : u;
   endfunction

endpackage

// File: rtl/fixedpoint_div.sv
// Sequential signed Q16.16 divider: radix-2 restoring, one quotient bit per cycle.
// Accepts in IDLE, runs DIV_STEPS CALC cycles, presents the result for one DONE cycle.
module fixedpoint_div
   import fixedpoint::*;
#(
   parameter bit SAT = 1'b1
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  in_valid,
   input  number num,
   input  number den,
   output logic  in_ready,
   output number quot,
   output logic  out_valid,
   output logic  div_zero
);

   localparam int CW = $clog2(DIV_STEPS);

   div_state_t             state;
   logic                   sign;
   logic                   num_neg;
   logic                   dz;
   logic [WIDTH-1:0]       den_mag;
   logic [WIDTH-1:0]       rem;
   logic [DIV_STEPS-1:0]   dvd;
   logic [DIV_STEPS-1:0]   q;
   logic [CW-1:0]          count;

   logic [WIDTH:0]         r_shift;
   logic [WIDTH:0]         r_sub;
   logic                   ge;
   logic [DIV_STEPS-1:0]   lim;

   // Remainder stays below den_mag, so one extra bit holds the shifted value.
   assign r_shift = {rem, dvd[DIV_STEPS-1]};
   assign r_sub   = r_shift - {1'b0, den_mag};
   assign ge      = (r_shift >= {1'b0, den_mag});

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         sign    <= 1'b0;
         num_neg <= 1'b0;
         dz      <= 1'b0;
         den_mag <= '0;
         rem     <= '0;
         dvd     <= '0;
         q       <= '0;
         count   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sign    <= num[WIDTH-1] ^ den[WIDTH-1];
                  num_neg <= num[WIDTH-1];
                  dz      <= (den == '0);
                  den_mag <= abs_u(den);
                  dvd     <= {abs_u(num), {FRAC{1'b0}}};
                  rem     <= '0;
                  q       <= '0;
                  count   <= CW'(DIV_STEPS - 1);
                  state   <= CALC;
               end
            end
            CALC: begin
               dvd <= {dvd[DIV_STEPS-2:0], 1'b0};
               rem <= ge ? r_sub[WIDTH-1:0] : r_shift[WIDTH-1:0];
               q   <= {q[DIV_STEPS-2:0], ge};
               if (count == '0) state <= DONE;
               else             count <= count - CW'(1);
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready = (state == IDLE);

   // Negative results may reach magnitude 2^31, positive ones only 2^31-1.
   assign lim = sign ? {{FRAC{1'b0}}, MIN_NEG} : {{FRAC{1'b0}}, MAX_POS};

   always_comb begin
      quot      = '0;
      out_valid = 1'b0;
      div_zero  = 1'b0;
      if (state == DONE) begin
         out_valid = 1'b1;
         if (dz) begin
            div_zero = 1'b1;
            quot     = num_neg ? MIN_NEG : MAX_POS;
         end else if (SAT && (q > lim)) begin
            quot = sign ? MIN_NEG : MAX_POS;
         end else begin
            quot = sign ? number'(-q[WIDTH-1:0]) : number'(q[WIDTH-1:0]);
         end
      end
   end

endmodule

// File: tb/tb_fixedpoint_div.sv
// Directed and random checks of fixedpoint_div (saturating and wrapping builds side by side)
// against an arithmetic reference model.
module tb_fixedpoint_div;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] num = '0;
   logic [31:0] den = '0;
   logic        in_ready, out_valid, div_zero;
   logic [31:0] quot;
   logic        in_ready_w, out_valid_w, div_zero_w;
   logic [31:0] quot_w;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fixedpoint_div #(.SAT(1'b1)) u_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .num(num), .den(den),
      .in_ready(in_ready), .quot(quot), .out_valid(out_valid), .div_zero(div_zero));

   fixedpoint_div #(.SAT(1'b0)) u_wrap (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .num(num), .den(den),
      .in_ready(in_ready_w), .quot(quot_w), .out_valid(out_valid_w), .div_zero(div_zero_w));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: exact integer quotient of |n|*2^16 / |d|, then sign, saturation or wrap.
   function automatic logic [31:0] ref_quot(input logic [31:0] n, input logic [31:0] d, input bit sat);
      longint sn, sd, nm, dm, qv, lim;
      bit     s;
      if (d == 32'h0) return n[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      sn  = longint'($signed(n));
      sd  = longint'($signed(d));
      nm  = (sn < 0) ? -sn : sn;
      dm  = (sd < 0) ? -sd : sd;
      qv  = (nm * 65536) / dm;
      s   = n[31] ^ d[31];
      lim = s ? 64'sd2147483648 : 64'sd2147483647;
      if (sat && qv > lim) return s ? 32'h8000_0000 : 32'h7FFF_FFFF;
      return s ? 32'(-qv) : 32'(qv);
   endfunction

   // Counts negedges from the accept edge until out_valid; flags any idle-cycle leakage.
   task automatic wait_out(output int lat, output bit stray);
      lat   = 0;
      stray = 1'b0;
      do begin
         @(negedge clk);
         lat++;
         if (!out_valid && (quot != 32'h0 || div_zero || in_ready)) stray = 1'b1;
         if (!out_valid_w && (quot_w != 32'h0 || div_zero_w || in_ready_w)) stray = 1'b1;
      end while (!out_valid && lat < 200);
   endtask

   task automatic run_div(input logic [31:0] n, input logic [31:0] d,
                          input logic [31:0] e_sat, input logic [31:0] e_wrap,
                          input logic e_dz, input string tag);
      int lat;
      bit stray;
      @(negedge clk);
      check({tag, " ready"}, 32'(in_ready), 32'h1);
      num = n; den = d; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      wait_out(lat, stray);
      check({tag, " latency"}, 32'(lat), 32'd49);
      check({tag, " quot_sat"}, quot, e_sat);
      check({tag, " quot_wrap"}, quot_w, e_wrap);
      check({tag, " div_zero"}, {30'h0, div_zero_w, div_zero}, {30'h0, e_dz, e_dz});
      check({tag, " busy_clean"}, {30'h0, stray, in_ready}, 32'h0);
      @(negedge clk);
      check({tag, " pulse_end"}, {30'h0, out_valid, out_valid_w}, 32'h0);
   endtask

   task automatic run_ref(input logic [31:0] n, input logic [31:0] d, input string tag);
      run_div(n, d, ref_quot(n, d, 1'b1), ref_quot(n, d, 1'b0), d == 32'h0, tag);
   endtask

   initial begin
      int lat;
      bit stray;
      int pulses;
      logic [31:0] rn, rd;

      // Reset
      repeat (3) @(negedge clk);
      check("reset ready", 32'(in_ready), 32'h1);
      check("reset outputs", {quot[29:0], out_valid, div_zero}, 32'h0);
      rst_n = 1'b1;

      // Basic and sign cases, checked against both constants and the model
      run_div(32'h0006_0000, 32'h0002_0000, 32'h0003_0000, 32'h0003_0000, 1'b0, "6/2");
      run_div(32'hFFFF_0000, 32'h0004_0000, 32'hFFFF_C000, 32'hFFFF_C000, 1'b0, "-1/4");
      run_div(32'h0001_0000, 32'h0003_0000, 32'h0000_5555, 32'h0000_5555, 1'b0, "1/3");
      run_div(32'h0001_0000, 32'hFFFD_0000, 32'hFFFF_AAAB, 32'hFFFF_AAAB, 1'b0, "1/-3");
      run_div(32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 32'h8000_0000, 1'b0, "min/1");
      check("model 1/-3", ref_quot(32'h0001_0000, 32'hFFFD_0000, 1'b1), 32'hFFFF_AAAB);

      // Divide by zero, identical in both builds
      run_div(32'h0005_0000, 32'h0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, "5/0");
      run_div(32'hFFFB_0000, 32'h0, 32'h8000_0000, 32'h8000_0000, 1'b1, "-5/0");

      // Overflow: saturate vs wrap
      run_div(32'h7FFF_0000, 32'h0000_8000, 32'h7FFF_FFFF, 32'hFFFE_0000, 1'b0, "ovf half");
      run_div(32'h8000_0000, 32'hFFFF_0000, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, "min/-1");

      // Busy: a second request during CALC is dropped
      @(negedge clk);
      num = 32'h0006_0000; den = 32'h0002_0000; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0; pulses = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 10) begin num = 32'h0003_0000; den = 32'h0001_0000; in_valid = 1'b1; end
         if (lat == 11) in_valid = 1'b0;
      end while (!out_valid && lat < 200);
      check("busy latency", 32'(lat), 32'd49);
      check("busy quot", quot, 32'h0003_0000);
      // Held through DONE, must be taken only in the following IDLE cycle
      num = 32'h0003_0000; den = 32'h0001_0000; in_valid = 1'b1;
      check("done not ready", 32'(in_ready), 32'h0);
      @(negedge clk);
      check("idle after done", {30'h0, in_ready, out_valid}, 32'h2);
      @(posedge clk);
      #1 in_valid = 1'b0;
      wait_out(lat, stray);
      check("retry latency", 32'(lat), 32'd49);
      check("retry quot", quot, 32'h0003_0000);
      check("retry clean", 32'(stray), 32'h0);
      @(negedge clk);

      // Reset mid-operation discards the division
      num = 32'h0006_0000; den = 32'h0002_0000; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("mid-reset state", {quot[29:0], in_ready, out_valid}, 32'h2);
      pulses = 0;
      repeat (60) begin
         @(negedge clk);
         if (out_valid || out_valid_w) pulses++;
      end
      check("mid-reset no pulse", 32'(pulses), 32'h0);
      run_div(32'h0006_0000, 32'h0002_0000, 32'h0003_0000, 32'h0003_0000, 1'b0, "post-reset 6/2");

      // Random operands against the model
      for (int i = 0; i < 30; i++) begin
         rn = 32'($signed($urandom) >>> $urandom_range(0, 24));
         case ($urandom_range(0, 3))
            0:       rd = $urandom;
            1:       rd = 32'($urandom_range(0, 65535));
            2:       rd = 32'h0;
            default: rd = 32'($signed($urandom) >>> $urandom_range(4, 28));
         endcase
         if ($urandom_range(0, 1) == 1) rd = -rd;
         run_ref(rn, rd, $sformatf("rand%0d %h/%h", i, rn, rd));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
